// File: rtl/data_packet_assembler_if.sv
// Stream bundle for data_packet_assembler: narrow packet input side plus assembled-frame output side.
// The assembler takes the slave view; the producer/consumer environment takes the master view.
interface data_packet_assembler_if #(
  parameter int PKT_W    = 1,
  parameter int NUM_PKTS = 4,
  parameter int CNT_W    = 3
);
  logic [PKT_W-1:0]          in_data;
  logic                      in_valid;
  logic                      in_last;
  logic                      in_ready;
  logic [PKT_W*NUM_PKTS-1:0] out_data;
  logic [CNT_W-1:0]          out_count;
  logic                      out_trunc;
  logic                      out_valid;
  logic                      out_ready;
  logic                      ovf_pulse;
  logic [7:0]                frame_cnt;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_count, out_trunc, out_valid, ovf_pulse, frame_cnt
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_count, out_trunc, out_valid, ovf_pulse, frame_cnt
  );
endinterface

// File: rtl/data_packet_assembler.sv
// Packs a frame of narrow packets into a NUM_PKTS-slot word and hands it off over valid/ready.
// Excess packets of an over-long frame are dropped and reported through out_trunc / ovf_pulse.
module data_packet_assembler #(
  parameter int PKT_W    = 1,
  parameter int NUM_PKTS = 4,
  parameter bit REVERSE  = 1'b1,
  parameter int CNT_W    = 3
) (
  input logic                  clock,
  input logic                  reset,
  data_packet_assembler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DROP    = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam int                 BUF_W = PKT_W * NUM_PKTS;
  localparam logic [CNT_W-1:0]   FULL  = CNT_W'(NUM_PKTS);
  localparam logic [CNT_W-1:0]   ONE   = CNT_W'(1);

  state_t             state_q, state_next;
  logic [BUF_W-1:0]   pkt_buf_q, pkt_buf_next;
  logic [CNT_W-1:0]   count_q, count_next;
  logic               trunc_q, trunc_next;
  logic               ovf_q, ovf_next;
  logic [7:0]         frame_q, frame_next;

  logic               ready;
  logic               accept;
  logic               wr_en;
  logic [CNT_W-1:0]   wr_idx;

  // Bit offset of arrival slot i inside the assembled word.
  function automatic int slot_base(input int i);
    return REVERSE ? (NUM_PKTS - 1 - i) * PKT_W : i * PKT_W;
  endfunction

  assign ready  = (state_q != HOLD);
  assign accept = bus.in_valid && ready;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_next   = state_q;
    pkt_buf_next = pkt_buf_q;
    count_next   = count_q;
    trunc_next   = trunc_q;
    ovf_next     = 1'b0;
    frame_next   = frame_q;
    wr_en        = 1'b0;
    wr_idx       = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_en      = 1'b1;
          wr_idx     = '0;
          count_next = ONE;
          state_next = bus.in_last ? HOLD : COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (count_q == FULL) begin
            // Buffer already full: this packet is the first excess one of the frame.
            ovf_next   = 1'b1;
            trunc_next = 1'b1;
            state_next = bus.in_last ? HOLD : DROP;
          end else begin
            wr_en      = 1'b1;
            wr_idx     = count_q;
            count_next = count_q + ONE;
            if (bus.in_last) state_next = HOLD;
          end
        end
      end
      DROP: begin
        if (accept && bus.in_last) state_next = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          pkt_buf_next = '0;
          count_next   = '0;
          trunc_next   = 1'b0;
          frame_next   = frame_q + 8'd1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    for (int i = 0; i < NUM_PKTS; i++) begin
      if (wr_en && (wr_idx == CNT_W'(i))) begin
        pkt_buf_next[slot_base(i) +: PKT_W] = bus.in_data;
      end
    end
  end

  // NOTE: the packet buffer is a flat register rather than a RAM, so it is reset along with the control state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pkt_buf_q <= '0;
      count_q   <= '0;
      trunc_q   <= 1'b0;
      ovf_q     <= 1'b0;
      frame_q   <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q   <= state_next;
      pkt_buf_q <= pkt_buf_next;
      count_q   <= count_next;
      trunc_q   <= trunc_next;
      ovf_q     <= ovf_next;
      frame_q   <= frame_next;
    end
  end

  // Outputs come straight from registers or the state decode; no in_* to out_* path.
  assign bus.in_ready  = ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_data  = pkt_buf_q;
  assign bus.out_count = count_q;
  assign bus.out_trunc = trunc_q;
  assign bus.ovf_pulse = ovf_q;
  assign bus.frame_cnt = frame_q;

endmodule

// File: tb/tb_data_packet_assembler.sv
// Directed bench for data_packet_assembler: one REVERSE=1 instance for all scenarios, one REVERSE=0
// instance for slot-order checking. Inputs change and outputs are sampled 1ns after the rising edge.
module tb_data_packet_assembler;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  int   exp_frames;

  data_packet_assembler_if #(.PKT_W(1), .NUM_PKTS(4), .CNT_W(3)) m0 ();
  data_packet_assembler_if #(.PKT_W(1), .NUM_PKTS(4), .CNT_W(3)) m1 ();

  data_packet_assembler #(.PKT_W(1), .NUM_PKTS(4), .REVERSE(1'b1), .CNT_W(3)) u_rev (
    .clock (clock),
    .reset (reset),
    .bus   (m0.slave)
  );

  data_packet_assembler #(.PKT_W(1), .NUM_PKTS(4), .REVERSE(1'b0), .CNT_W(3)) u_fwd (
    .clock (clock),
    .reset (reset),
    .bus   (m1.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offers one packet on m0 and returns 1ns after the edge that accepts it.
  task automatic send(input logic d, input logic l);
    bit done;
    done = 1'b0;
    m0.in_data  = d;
    m0.in_last  = l;
    m0.in_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      if (m0.in_ready) done = 1'b1;
      tick();
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for 20 cycles, required 1");
    end
    m0.in_valid = 1'b0;
    m0.in_last  = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [3:0] data,
                             input logic [2:0] cnt, input logic trunc);
    checks++;
    if (m0.out_valid !== 1'b1 || m0.out_data !== data || m0.out_count !== cnt ||
        m0.out_trunc !== trunc || m0.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s: valid=%b data=%b count=%0d trunc=%b in_ready=%b, required valid=1 data=%b count=%0d trunc=%b in_ready=0",
               name, m0.out_valid, m0.out_data, m0.out_count, m0.out_trunc, m0.in_ready,
               data, cnt, trunc);
    end
  endtask

  task automatic check_delivered(input string name);
    exp_frames = (exp_frames + 1) % 256;
    checks++;
    if (m0.out_valid !== 1'b0 || m0.in_ready !== 1'b1 || m0.frame_cnt !== 8'(exp_frames)) begin
      failures++;
      $display("FAIL %s: valid=%b in_ready=%b frame_cnt=%0d, required valid=0 in_ready=1 frame_cnt=%0d",
               name, m0.out_valid, m0.in_ready, m0.frame_cnt, exp_frames);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (m0.in_ready !== 1'b1 || m0.out_valid !== 1'b0 || m0.out_data !== 4'b0000 ||
        m0.out_count !== 3'd0 || m0.out_trunc !== 1'b0 || m0.ovf_pulse !== 1'b0 ||
        m0.frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b valid=%b data=%b count=%0d trunc=%b ovf=%b frames=%0d, required 1 0 0000 0 0 0 0",
               m0.in_ready, m0.out_valid, m0.out_data, m0.out_count, m0.out_trunc,
               m0.ovf_pulse, m0.frame_cnt);
    end
    exp_frames = 0;
    #3 reset = 1'b0;
    tick();
  endtask

  task automatic test_frame_order();
    m0.out_ready = 1'b1;
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    check_frame("frame_order", 4'b1011, 3'd4, 1'b0);
    checks++;
    if (m0.frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL frame_order_cnt_before: frame_cnt=%0d, required 0", m0.frame_cnt);
    end
    tick();
    check_delivered("frame_order_delivered");
  endtask

  task automatic test_short_frame();
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    check_frame("short_rev", 4'b1100, 3'd2, 1'b0);
    tick();
    check_delivered("short_rev_delivered");

    m1.out_ready = 1'b0;
    m1.in_data   = 1'b1;
    m1.in_last   = 1'b0;
    m1.in_valid  = 1'b1;
    tick();
    m1.in_last   = 1'b1;
    tick();
    m1.in_valid  = 1'b0;
    m1.in_last   = 1'b0;
    checks++;
    if (m1.out_valid !== 1'b1 || m1.out_data !== 4'b0011 || m1.out_count !== 3'd2 ||
        m1.out_trunc !== 1'b0) begin
      failures++;
      $display("FAIL short_fwd: valid=%b data=%b count=%0d trunc=%b, required 1 0011 2 0",
               m1.out_valid, m1.out_data, m1.out_count, m1.out_trunc);
    end
    m1.out_ready = 1'b1;
    tick();
    checks++;
    if (m1.out_valid !== 1'b0 || m1.frame_cnt !== 8'd1) begin
      failures++;
      $display("FAIL short_fwd_delivered: valid=%b frame_cnt=%0d, required 0 1",
               m1.out_valid, m1.frame_cnt);
    end
  endtask

  task automatic test_overflow();
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    checks++;
    if (m0.ovf_pulse !== 1'b0) begin
      failures++;
      $display("FAIL ovf_early: ovf_pulse=%b after 4th accept, required 0", m0.ovf_pulse);
    end
    send(1'b1, 1'b0);
    checks++;
    if (m0.ovf_pulse !== 1'b1) begin
      failures++;
      $display("FAIL ovf_pulse: ovf_pulse=%b after 5th accept, required 1", m0.ovf_pulse);
    end
    send(1'b1, 1'b1);
    checks++;
    if (m0.ovf_pulse !== 1'b0) begin
      failures++;
      $display("FAIL ovf_width: ovf_pulse=%b after 6th accept, required 0", m0.ovf_pulse);
    end
    check_frame("overflow", 4'b1001, 3'd4, 1'b1);
    tick();
    check_delivered("overflow_delivered");
    checks++;
    if (m0.out_trunc !== 1'b0 || m0.out_count !== 3'd0) begin
      failures++;
      $display("FAIL overflow_clear: trunc=%b count=%0d, required 0 0", m0.out_trunc, m0.out_count);
    end
  endtask

  task automatic test_backpressure();
    m0.out_ready = 1'b0;
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    m0.in_data  = 1'b1;
    m0.in_last  = 1'b1;
    m0.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_frame("backpressure_hold", 4'b0110, 3'd4, 1'b0);
    end
    m0.out_ready = 1'b1;
    tick();
    check_delivered("backpressure_release");
    tick();
    m0.in_valid = 1'b0;
    m0.in_last  = 1'b0;
    check_frame("backpressure_held_pkt", 4'b1000, 3'd1, 1'b0);
    tick();
    check_delivered("backpressure_held_delivered");
  endtask

  task automatic test_reset_mid_frame();
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (m0.in_ready !== 1'b1 || m0.out_valid !== 1'b0 || m0.out_count !== 3'd0 ||
        m0.out_data !== 4'b0000 || m0.frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid_frame: in_ready=%b valid=%b count=%0d data=%b frames=%0d, required 1 0 0 0000 0",
               m0.in_ready, m0.out_valid, m0.out_count, m0.out_data, m0.frame_cnt);
    end
    exp_frames = 0;
    #2 reset = 1'b0;
    tick();
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    check_frame("after_reset_frame", 4'b1010, 3'd4, 1'b0);
    tick();
    check_delivered("after_reset_delivered");
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    #2 reset = 1'b0;
    exp_frames = 0;
    tick();
    m0.out_ready = 1'b1;
    for (int f = 1; f <= 256; f++) begin
      send(1'b1, 1'b1);
      tick();
      if (f == 255) begin
        checks++;
        if (m0.frame_cnt !== 8'd255) begin
          failures++;
          $display("FAIL wrap_255: frame_cnt=%0d, required 255", m0.frame_cnt);
        end
      end
    end
    checks++;
    if (m0.frame_cnt !== 8'd0) begin
      failures++;
      $display("FAIL wrap_0: frame_cnt=%0d, required 0", m0.frame_cnt);
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    exp_frames   = 0;
    m0.in_data   = 1'b0;
    m0.in_valid  = 1'b0;
    m0.in_last   = 1'b0;
    m0.out_ready = 1'b0;
    m1.in_data   = 1'b0;
    m1.in_valid  = 1'b0;
    m1.in_last   = 1'b0;
    m1.out_ready = 1'b0;
    reset        = 1'b0;
    #1;
    test_reset();
    test_frame_order();
    test_short_frame();
    test_overflow();
    test_backpressure();
    test_reset_mid_frame();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_packet_assembler.md
Name: data_packet_assembler

Overview:
- Upstream feeder for the received-data buffer stage.
- Collects narrow data packets from a valid/ready stream into a NUM_PKTS-slot buffer, with optional order reversal.
- Delivers the assembled word, its packet count and a truncation flag over a valid/ready output handshake when the last packet of a frame arrives.
- Counts delivered frames and flags overflow when a frame has more packets than the buffer holds.

Parameters:
- PKT_W, 1: width of one packet in bits.
- NUM_PKTS, 4: buffer depth in packets; must be at least 2.
- REVERSE, 1: 1 places arrival slot 0 at the MSB end; 0 places slot 0 at the LSB end.
- CNT_W, 3: width of out_count; must satisfy 2^CNT_W > NUM_PKTS.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  PKT_W  packet payload.
- in_valid  in  1  packet present.
- in_last  in  1  packet is the last of its frame; qualified by in_valid.
- in_ready  out  1  block can accept a packet.
- out_data  out  PKT_W*NUM_PKTS  assembled buffer.
- out_count  out  CNT_W  number of packets stored, 1..NUM_PKTS.
- out_trunc  out  1  frame exceeded NUM_PKTS and excess packets were discarded.
- out_valid  out  1  assembled frame available.
- out_ready  in  1  consumer accepts the frame.
- ovf_pulse  out  1  one-cycle pulse on the first overflow of a frame.
- frame_cnt  out  8  count of delivered frames, wraps modulo 256.

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - state = IDLE; buffer, out_count and frame_cnt = 0.
  - out_valid, out_trunc, ovf_pulse = 0.
  - A frame in progress or pending at reset is discarded.
- Accept: a packet is accepted when in_valid && in_ready at a rising clock edge.
- in_ready is decoded from state only: 1 in IDLE, COLLECT and DROP; 0 in HOLD.
- Slot placement for the packet in arrival slot i (0-based):
  - REVERSE=1: out_data[(NUM_PKTS-1-i)*PKT_W +: PKT_W].
  - REVERSE=0: out_data[i*PKT_W +: PKT_W].
  - Unfilled slots read 0.
- IDLE:
  - On accept: write slot 0, count = 1.
  - in_last=1: go to HOLD. Otherwise: go to COLLECT.
- COLLECT with count < NUM_PKTS:
  - On accept: write slot count, count += 1.
  - in_last=1: go to HOLD. Otherwise stay in COLLECT.
  - Reaching count == NUM_PKTS without in_last keeps the state in COLLECT.
- COLLECT with count == NUM_PKTS, on accept (overflow):
  - The packet is discarded; the buffer is unchanged.
  - ovf_pulse = 1 for exactly one cycle after that edge; out_trunc is set.
  - in_last=1: go to HOLD. Otherwise: go to DROP.
- DROP:
  - Every accepted packet is discarded; ovf_pulse does not re-fire.
  - Accepted in_last=1: go to HOLD.
- HOLD:
  - out_valid = 1; out_data, out_count and out_trunc are held stable.
  - On out_valid && out_ready: buffer, count and out_trunc clear to 0; frame_cnt += 1 (255 wraps to 0); go to IDLE.
- Latency and throughput:
  - out_valid rises on the edge that accepts the last packet, so it is visible the cycle after the last-packet handshake.
  - The earliest next accept is the cycle after the output handshake.
  - Minimum frame period is N+1 cycles for an N-packet frame.
- Outside HOLD, out_data shows the partial buffer and out_count the running count. Both are deterministic, but the bench checks them only when out_valid=1.
- in_last with in_valid=0 is ignored.
- All outputs are registered or decoded from state only; there is no combinational path from in_* to out_*.

Test Plan:
- Frame order: reset; packets 1,0,1,1 with in_last on the 4th; out_ready=1; REVERSE=1 -> out_valid high the cycle after the 4th accept, out_data=4'b1011, out_count=4, out_trunc=0, frame_cnt 0->1.
- Short frame: packets 1,1 with in_last on the 2nd -> out_data=4'b1100, out_count=2, out_trunc=0; REVERSE=0 build -> out_data=4'b0011.
- Overflow: packets 1,0,0,1,1,1 with in_last on the 6th -> ovf_pulse high exactly one cycle after the 5th accept; out_data=4'b1001, out_count=4, out_trunc=1.
- Backpressure: complete a frame with out_ready=0 for 5 cycles while in_valid=1 -> out_valid and out_data stable, in_ready=0, no packet consumed; raise out_ready -> handshake, then the held input packet is accepted into slot 0 the next cycle.
- Reset mid-frame: assert reset asynchronously after 2 accepted packets -> in_ready=1, out_valid=0, count=0; the next frame of 1,0,1,0 -> out_data=4'b1010.
- Wrap-around: deliver 256 one-packet frames -> frame_cnt reads 255 after 255 deliveries and 0 after the 256th.
